// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32 subset datapath.
//
// Sequences each instruction through IF -> ID -> EX -> (MEM) -> WB and decodes
// R, I, LW, SW and BR opcodes into datapath strobes. Data memory accesses wait
// for dReady up to MEM_WAIT_MAX cycles. An illegal instruction or a memory
// timeout parks the FSM in HALT with a sticky fault until rst.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   instr     - current instruction, stable from ID through WB
//   zero      - ALU zero flag, selects branch outcome in WB
//   dReady    - data memory completion, sampled in MEM only
//   PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC - datapath controls
//   ALUCtrl   - ALU operation select
//   MemRead, MemWrite - data memory strobes
//   state     - current FSM state (debug)
//   fault     - sticky error flag
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        dReady,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        loadPC,
    output logic [3:0]  ALUCtrl,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  state,
    output logic        fault
);

    localparam logic [2:0] S_IF   = 3'b000;
    localparam logic [2:0] S_ID   = 3'b001;
    localparam logic [2:0] S_EX   = 3'b010;
    localparam logic [2:0] S_MEM  = 3'b011;
    localparam logic [2:0] S_WB   = 3'b100;
    localparam logic [2:0] S_HALT = 3'b101;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [8:0] WAIT_LIMIT = 9'(MEM_WAIT_MAX);

    logic [2:0] r_state;
    logic [7:0] r_wait_cnt;
    logic       r_fault;

    logic [2:0] w_state_d;
    logic [7:0] w_wait_cnt_d;
    logic [8:0] w_wait_inc;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_is_r;
    logic       w_is_i;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_br;
    logic       w_legal;
    logic [3:0] w_alu;
    logic       w_unused;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_is_r   = (w_opcode == OP_R);
    assign w_is_i   = (w_opcode == OP_I);
    assign w_is_lw  = (w_opcode == OP_LW);
    assign w_is_sw  = (w_opcode == OP_SW);
    assign w_is_br  = (w_opcode == OP_BR);

    // Register numbers and immediates belong to the datapath.
    assign w_unused = ^{instr[24:15], instr[11:7]};

    // Instruction decode: ALU operation and legality.
    always_comb begin
        w_alu   = ALU_ADD;
        w_legal = 1'b0;
        case (w_opcode)
            OP_R, OP_I: begin
                w_legal = 1'b1;
                case (w_funct3)
                    3'b000: begin
                        // I-type has an immediate here, so funct7 is ignored.
                        if (w_is_i || w_funct7 == F7_BASE) begin
                            w_alu = ALU_ADD;
                        end else if (w_funct7 == F7_ALT) begin
                            w_alu = ALU_SUB;
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                    3'b101: begin
                        if (w_is_i) begin
                            w_alu = instr[30] ? ALU_SRA : ALU_SRL;
                        end else if (w_funct7 == F7_BASE) begin
                            w_alu = ALU_SRL;
                        end else if (w_funct7 == F7_ALT) begin
                            w_alu = ALU_SRA;
                        end else begin
                            w_legal = 1'b0;
                        end
                    end
                    3'b111:  w_alu = ALU_AND;
                    3'b110:  w_alu = ALU_OR;
                    3'b100:  w_alu = ALU_XOR;
                    3'b010:  w_alu = ALU_SLT;
                    3'b001:  w_alu = ALU_SLL;
                    default: w_legal = 1'b0;
                endcase
            end
            OP_LW, OP_SW: begin
                w_legal = 1'b1;
                w_alu   = ALU_ADD;
            end
            OP_BR: begin
                w_alu   = ALU_SUB;
                w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b001);
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;

    // Next-state logic.
    always_comb begin
        w_state_d    = r_state;
        w_wait_cnt_d = r_wait_cnt;
        case (r_state)
            S_IF: w_state_d = S_ID;
            S_ID: w_state_d = w_legal ? S_EX : S_HALT;
            S_EX: begin
                if (w_is_lw || w_is_sw) begin
                    w_state_d    = S_MEM;
                    w_wait_cnt_d = 8'd0;
                end else begin
                    w_state_d = S_WB;
                end
            end
            S_MEM: begin
                // Completion wins over a timeout landing in the same cycle.
                if (dReady) begin
                    w_state_d = S_WB;
                end else begin
                    w_wait_cnt_d = w_wait_inc[7:0];
                    if (w_wait_inc >= WAIT_LIMIT) begin
                        w_state_d = S_HALT;
                    end
                end
            end
            S_WB:    w_state_d = S_IF;
            S_HALT:  w_state_d = S_HALT;
            default: w_state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IF;
            r_wait_cnt <= 8'd0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
            if (w_state_d == S_HALT) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Outputs depend only on registered state, instr and zero.
    always_comb begin
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        loadPC   = 1'b0;
        ALUCtrl  = 4'b0000;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (r_state == S_EX || r_state == S_MEM || r_state == S_WB) begin
            ALUCtrl = w_alu;
            ALUSrc  = w_is_i || w_is_lw || w_is_sw;
        end
        if (r_state == S_MEM) begin
            MemRead  = w_is_lw;
            MemWrite = w_is_sw;
        end
        if (r_state == S_WB) begin
            loadPC   = 1'b1;
            RegWrite = w_is_r || w_is_i || w_is_lw;
            MemtoReg = w_is_lw;
            PCSrc    = w_is_br && (((w_funct3 == 3'b000) && zero) ||
                                   ((w_funct3 == 3'b001) && !zero));
        end
    end

    assign state = r_state;
    assign fault = r_fault;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed instruction vectors, a trace model
// that predicts every cycle's outputs, and literal spot checks.
module tb_multicycle_ctrl;

    localparam int unsigned WAIT_MAX = 4;

    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LW  = 2;
    localparam int K_SW  = 3;
    localparam int K_BR  = 4;
    localparam int K_ILL = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        dReady;
    logic        PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC;
    logic [3:0]  ALUCtrl;
    logic        MemRead, MemWrite;
    logic [2:0]  state;
    logic        fault;

    typedef struct packed {
        logic [2:0] st;
        logic       pcsrc;
        logic       alusrc;
        logic       regwrite;
        logic       memtoreg;
        logic       loadpc;
        logic [3:0] alu;
        logic       memread;
        logic       memwrite;
        logic       flt;
    } out_t;

    out_t dut_o;
    assign dut_o = {state, PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC, ALUCtrl,
                    MemRead, MemWrite, fault};

    out_t exp_q[$];
    out_t cur_e;
    out_t wb_o;
    int   n_vec = 0;
    int   n_err = 0;
    int   rw_cnt = 0, lpc_cnt = 0, mr_cnt = 0, mw_cnt = 0;
    int   lat = 0, last_lat = 0;

    multicycle_ctrl #(
        .MEM_WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .dReady(dReady),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .loadPC(loadPC), .ALUCtrl(ALUCtrl), .MemRead(MemRead), .MemWrite(MemWrite),
        .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    // ALU code for funct3 values that have a single meaning; 4'hF = none.
    function automatic logic [3:0] plain_f3(input logic [2:0] f3);
        case (f3)
            3'b111:  return 4'b0000;
            3'b110:  return 4'b0001;
            3'b100:  return 4'b1101;
            3'b010:  return 4'b0111;
            3'b001:  return 4'b1001;
            default: return 4'hF;
        endcase
    endfunction

    function automatic void classify(input logic [31:0] ins, output int kind,
                                     output logic [3:0] alu);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op   = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        kind = K_ILL;
        alu  = 4'hF;
        if (op == 7'b0110011) begin
            case ({f7, f3})
                10'b0000000_000: alu = 4'b0010;
                10'b0100000_000: alu = 4'b0110;
                10'b0000000_101: alu = 4'b1000;
                10'b0100000_101: alu = 4'b1010;
                default:         alu = plain_f3(f3);
            endcase
            if (alu != 4'hF) kind = K_R;
        end else if (op == 7'b0010011) begin
            if (f3 == 3'b000)      alu = 4'b0010;
            else if (f3 == 3'b101) alu = ins[30] ? 4'b1010 : 4'b1000;
            else                   alu = plain_f3(f3);
            if (alu != 4'hF) kind = K_I;
        end else if (op == 7'b0000011) begin
            kind = K_LW; alu = 4'b0010;
        end else if (op == 7'b0100011) begin
            kind = K_SW; alu = 4'b0010;
        end else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
            kind = K_BR; alu = 4'b0110;
        end
    endfunction

    // Expected outputs while the FSM sits in state code st.
    function automatic out_t expo(input logic [2:0] st, input logic [31:0] ins,
                                  input logic z, input logic flt);
        out_t       o;
        int         kind;
        logic [3:0] alu;
        classify(ins, kind, alu);
        o     = '0;
        o.st  = st;
        o.flt = flt;
        if (st == 3'd2 || st == 3'd3 || st == 3'd4) begin
            o.alu    = alu;
            o.alusrc = (kind == K_I || kind == K_LW || kind == K_SW);
        end
        if (st == 3'd3) begin
            o.memread  = (kind == K_LW);
            o.memwrite = (kind == K_SW);
        end
        if (st == 3'd4) begin
            o.loadpc   = 1'b1;
            o.regwrite = (kind == K_R || kind == K_I || kind == K_LW);
            o.memtoreg = (kind == K_LW);
            o.pcsrc    = (kind == K_BR) && ((ins[14:12] == 3'b000) ? z : !z);
        end
        return o;
    endfunction

    task automatic cyc(input logic rs, input logic [31:0] ins, input logic z,
                       input logic dr, input out_t e);
        rst    = rs;
        instr  = ins;
        zero   = z;
        dReady = dr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Whole instruction from IF. waits = dReady-low MEM cycles before dReady.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int waits);
        int         kind;
        logic [3:0] alu;
        int         n_mem;
        classify(ins, kind, alu);
        cyc(1'b0, ins, z, rnd(), expo(3'd0, ins, z, 1'b0));
        cyc(1'b0, ins, z, rnd(), expo(3'd1, ins, z, 1'b0));
        if (kind == K_ILL) begin
            for (int i = 0; i < 3; i++) cyc(1'b0, ins, z, rnd(), expo(3'd5, ins, z, 1'b1));
            return;
        end
        cyc(1'b0, ins, z, rnd(), expo(3'd2, ins, z, 1'b0));
        if (kind == K_LW || kind == K_SW) begin
            n_mem = (waits >= int'(WAIT_MAX)) ? int'(WAIT_MAX) : waits + 1;
            for (int k = 0; k < n_mem; k++) begin
                cyc(1'b0, ins, z, (k == waits), expo(3'd3, ins, z, 1'b0));
            end
            if (waits >= int'(WAIT_MAX)) begin
                for (int i = 0; i < 3; i++) cyc(1'b0, ins, z, rnd(), expo(3'd5, ins, z, 1'b1));
                return;
            end
        end
        cyc(1'b0, ins, z, rnd(), expo(3'd4, ins, z, 1'b0));
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Per-cycle comparison against the model trace, plus activity tracking.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                cur_e = exp_q.pop_front();
                n_vec++;
                if (dut_o !== cur_e) begin
                    n_err++;
                    $display("FAIL cycle_compare t=%0t got %b want %b", $time, dut_o, cur_e);
                end
            end
            rw_cnt  = rw_cnt + int'(RegWrite);
            lpc_cnt = lpc_cnt + int'(loadPC);
            mr_cnt  = mr_cnt + int'(MemRead);
            mw_cnt  = mw_cnt + int'(MemWrite);
            if (state == 3'b000) lat = 1;
            else lat = lat + 1;
            if (state == 3'b100) begin
                last_lat = lat;
                wb_o     = dut_o;
            end
        end
    end

    logic [31:0] leg_ins [14] = '{
        32'h00209863, 32'h00209863, 32'h00108093, 32'h4010D093, 32'hFFF0C093,
        32'h402081B3, 32'h4020D1B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020A1B3,
        32'h002091B3, 32'h0020D1B3, 32'h0080A283, 32'h0020A423
    };
    logic        leg_z   [14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int          leg_w   [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic [31:0] ill_ins [6]  = '{
        32'h022081B3, 32'h0020A063, 32'h0010B093, 32'h0220D1B3, 32'h0020B1B3,
        32'h0000C0FF
    };

    initial begin
        int          b0, b1;
        logic [31:0] sw_i;
        rst    = 1'b1;
        instr  = 32'h0;
        zero   = 1'b0;
        dReady = 1'b0;
        sw_i   = 32'h0020A423;
        @(posedge clk);
        #1;
        lit("reset_state", 32'(state), 32'd0);
        lit("reset_fault", 32'(fault), 32'd0);
        lit("reset_outputs", 32'({PCSrc, ALUSrc, RegWrite, MemtoReg, loadPC, ALUCtrl,
                                  MemRead, MemWrite}), 32'd0);

        run_instr(32'h002081B3, 1'b0, 0);
        lit("add_latency", 32'(last_lat), 32'd4);
        lit("add_wb_alu", 32'(wb_o.alu), 32'h2);
        lit("add_wb_regwrite", 32'(wb_o.regwrite), 32'd1);
        lit("add_wb_alusrc", 32'(wb_o.alusrc), 32'd0);
        lit("add_wb_loadpc", 32'(wb_o.loadpc), 32'd1);
        lit("add_wb_pcsrc", 32'(wb_o.pcsrc), 32'd0);

        b0 = mr_cnt;
        run_instr(32'h0080A283, 1'b0, 2);
        lit("lw_memread_cycles", 32'(mr_cnt - b0), 32'd3);
        lit("lw_latency", 32'(last_lat), 32'd7);
        lit("lw_wb_regwrite", 32'(wb_o.regwrite), 32'd1);
        lit("lw_wb_memtoreg", 32'(wb_o.memtoreg), 32'd1);

        run_instr(32'h00208863, 1'b1, 0);
        lit("beq_taken_pcsrc", 32'(wb_o.pcsrc), 32'd1);
        lit("beq_alu", 32'(wb_o.alu), 32'h6);
        lit("beq_regwrite", 32'(wb_o.regwrite), 32'd0);
        run_instr(32'h00208863, 1'b0, 0);
        lit("beq_not_taken_pcsrc", 32'(wb_o.pcsrc), 32'd0);

        for (int i = 0; i < 14; i++) run_instr(leg_ins[i], leg_z[i], leg_w[i]);

        // dReady arriving exactly as the wait limit is reached still completes.
        run_instr(sw_i, 1'b0, int'(WAIT_MAX) - 1);
        lit("sw_limit_latency", 32'(last_lat), 32'(5 + WAIT_MAX - 1));
        lit("sw_limit_no_fault", 32'(wb_o.flt), 32'd0);

        b0 = mw_cnt;
        run_instr(sw_i, 1'b0, 99);
        lit("sw_timeout_memwrite_cycles", 32'(mw_cnt - b0), 32'(WAIT_MAX));
        lit("sw_timeout_state", 32'(state), 32'd5);
        lit("sw_timeout_fault", 32'(fault), 32'd1);
        cyc(1'b1, sw_i, 1'b0, 1'b0, expo(3'd5, sw_i, 1'b0, 1'b1));
        lit("sw_timeout_rst_state", 32'(state), 32'd0);
        lit("sw_timeout_rst_fault", 32'(fault), 32'd0);

        b0 = rw_cnt;
        b1 = lpc_cnt;
        run_instr(32'h0000007F, 1'b0, 0);
        lit("ill7f_fault", 32'(fault), 32'd1);
        cyc(1'b1, 32'h0000007F, 1'b0, 1'b0, expo(3'd5, 32'h0000007F, 1'b0, 1'b1));
        lit("ill7f_no_regwrite", 32'(rw_cnt - b0), 32'd0);
        lit("ill7f_no_loadpc", 32'(lpc_cnt - b1), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_instr(ill_ins[i], 1'b0, 0);
            cyc(1'b1, ill_ins[i], 1'b0, 1'b0, expo(3'd5, ill_ins[i], 1'b0, 1'b1));
        end

        // Reset in the 2nd MEM cycle of lw, with dReady high to test priority.
        b0 = rw_cnt;
        cyc(1'b0, 32'h0080A283, 1'b0, 1'b0, expo(3'd0, 32'h0080A283, 1'b0, 1'b0));
        cyc(1'b0, 32'h0080A283, 1'b0, 1'b0, expo(3'd1, 32'h0080A283, 1'b0, 1'b0));
        cyc(1'b0, 32'h0080A283, 1'b0, 1'b0, expo(3'd2, 32'h0080A283, 1'b0, 1'b0));
        cyc(1'b0, 32'h0080A283, 1'b0, 1'b0, expo(3'd3, 32'h0080A283, 1'b0, 1'b0));
        cyc(1'b1, 32'h0080A283, 1'b0, 1'b1, expo(3'd3, 32'h0080A283, 1'b0, 1'b0));
        lit("rst_mem_state", 32'(state), 32'd0);
        lit("rst_mem_memread", 32'(MemRead), 32'd0);
        run_instr(32'h002081B3, 1'b0, 0);
        lit("rst_mem_no_stray_regwrite", 32'(rw_cnt - b0), 32'd1);

        lit("trace_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_WAIT_MAX, default 16, meaning the maximum number of MEM-state cycles spent waiting for dReady before a fault is raised (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port instr, input, 32 bits: current instruction, held stable by the fetch path from ID through WB.
REQ-005 The block SHALL have port zero, input, 1 bit: the ALU zero flag from the datapath.
REQ-006 The block SHALL have port dReady, input, 1 bit: data memory completion for the current MemRead/MemWrite.
REQ-007 The block SHALL have outputs PCSrc, ALUSrc, RegWrite, MemtoReg and loadPC, 1 bit each, driving the datapath inputs of the same names.
REQ-008 The block SHALL have port ALUCtrl, output, 4 bits: ALU operation select.
REQ-009 The block SHALL have ports MemRead and MemWrite, output, 1 bit each: data memory strobes.
REQ-010 The block SHALL have port state, output, 3 bits: current FSM state, for debug.
REQ-011 The block SHALL have port fault, output, 1 bit: sticky error flag.

Function
REQ-012 The FSM SHALL use these encodings: IF=000, ID=001, EX=010, MEM=011, WB=100, HALT=101; codes 110 and 111 go to HALT on the next edge.
REQ-013 Opcodes SHALL be decoded as: R=0110011, I=0010011, LW=0000011, SW=0100011, BR=1100011; any other opcode is illegal.
REQ-014 ALUCtrl SHALL be encoded as: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SRL=1000, SLL=1001, SRA=1010, XOR=1101.
REQ-015 R-type decode (funct3/funct7) SHALL be: 000/0000000 ADD; 000/0100000 SUB; 111 AND; 110 OR; 100 XOR; 010 SLT; 001 SLL; 101/0000000 SRL; 101/0100000 SRA; any other combination is illegal.
REQ-016 I-type decode SHALL match R-type, except that funct3=000 is always ADD and funct3=101 uses instr[30] to select SRA (1) or SRL (0).
REQ-017 LW and SW SHALL use ADD; BR SHALL use SUB.
REQ-018 Only BR funct3 000 (BEQ) and 001 (BNE) are legal; any other BR funct3 is illegal.
REQ-019 IF SHALL last one cycle, assert no strobes, and go to ID.
REQ-020 ID SHALL last one cycle; an illegal instruction goes to HALT, otherwise the FSM goes to EX.
REQ-021 In EX, MEM and WB, ALUCtrl SHALL be driven from decode, and ALUSrc SHALL be 1 for I, LW and SW and 0 otherwise; in all other states both SHALL be 0.
REQ-022 EX SHALL last one cycle and go to MEM for LW/SW, otherwise to WB.
REQ-023 In MEM, MemRead SHALL be 1 for LW and MemWrite SHALL be 1 for SW, held continuously until dReady is sampled high.
REQ-024 An 8-bit wait counter SHALL clear on MEM entry and increment each MEM cycle with dReady=0.
REQ-025 dReady=1 in MEM SHALL move the FSM to WB on the next edge, and the strobes SHALL drop in WB.
REQ-026 If the wait counter reaches MEM_WAIT_MAX with dReady still 0, the FSM SHALL go to HALT.
REQ-027 In MEM, dReady=1 in the same cycle the count reaches the limit SHALL take priority, giving WB with no fault.
REQ-028 WB SHALL last one cycle with loadPC=1 and then go to IF.
REQ-029 In WB, RegWrite SHALL be 1 for R, I and LW; MemtoReg SHALL be 1 for LW only; PCSrc SHALL equal zero for BEQ, !zero for BNE, and 0 otherwise.
REQ-030 loadPC, RegWrite, MemtoReg and PCSrc SHALL be 0 in every state other than WB.
REQ-031 Each instruction's latency SHALL be: R, I and BR take 4 cycles; LW and SW take 5 cycles plus the number of dReady wait cycles.
REQ-032 HALT SHALL assert fault=1, hold all strobes at 0, and be left only by rst.
REQ-033 fault SHALL be set on the HALT entry edge and never cleared except by rst.
REQ-034 All outputs SHALL be glitch-free functions of the registered state plus instr/zero; there are no combinational paths from dReady to any output.

Reset
REQ-035 When rst=1 on a rising clk edge, state SHALL become IF, the wait counter 0 and fault 0; every output is 0 in the cycle that follows.
REQ-036 rst SHALL take priority over every transition, including mid-MEM, where MemRead/MemWrite drop on the reset edge and no WB occurs.

Verification
REQ-037 add x3,x1,x2 (0x002081B3) SHALL give states IF,ID,EX,WB; in WB RegWrite=1, ALUCtrl=0010, ALUSrc=0, loadPC=1, PCSrc=0.
REQ-038 lw x5,8(x1) (0x0080A283) with dReady high on the 3rd MEM cycle SHALL hold MemRead for 3 cycles; WB then has RegWrite=1, MemtoReg=1, and the total is 7 cycles.
REQ-039 beq x1,x2,+16 (0x00208863) SHALL give PCSrc=1 in WB with zero=1, and PCSrc=0 in WB with zero=0; ALUCtrl=0110 and RegWrite=0.
REQ-040 sw with dReady held 0 and MEM_WAIT_MAX=4 SHALL give HALT after 4 MEM cycles with fault=1; a subsequent rst pulse returns state=000 and fault=0.
REQ-041 Opcode 0x7F in ID SHALL give HALT next cycle with fault=1 and no loadPC or RegWrite ever asserted.
REQ-042 rst asserted during the 2nd MEM cycle of an lw SHALL make MemRead 0 and state=000 after that edge, with no RegWrite pulse.
